kb_event_queue: RTL

//   Converts the PS/2 scan-code byte stream into whole key events (make/break, extended)
//   and queues them in a small FIFO for the PicoBlaze.

---
 rtl/kb_event_queue.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/kb_event_queue.sv
// kb_event_queue
//   Assembles PS/2 scan-code bytes into whole key events and queues them for
//   the PicoBlaze. E0 and F0 prefixes are folded into flag bits. BAT, ack and
//   echo bytes are discarded. The PicoBlaze reads the head entry through its
//   own port addresses. A committed read of the flags port pops the entry.
//
//   Entry format: {brk, ext, code[7:0]}
//
// Ports
//   CLK            system clock, rising edge
//   RESET          asynchronous active-high reset
//   Code_Valid     one-cycle strobe, new byte from the PS/2 receiver
//   Code_Byte      received scan-code byte
//   Port_ID        PicoBlaze port address
//   Read_Strobe    PicoBlaze read commit
//   Port_Out       read data (combinational from Port_ID and state)
//   Event_Pending  registered, FIFO not empty
//   Overflow       registered sticky, an event was dropped on a full FIFO
module kb_event_queue #(
  parameter int          DEPTH       = 4,
  parameter logic [7:0]  PORT_STATUS = 8'h10,
  parameter logic [7:0]  PORT_KEY    = 8'h11,
  parameter logic [7:0]  PORT_FLAGS  = 8'h12
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       Code_Valid,
  input  logic [7:0] Code_Byte,
  input  logic [7:0] Port_ID,
  input  logic       Read_Strobe,
  output logic [7:0] Port_Out,
  output logic       Event_Pending,
  output logic       Overflow
);

  localparam int         PTR_W    = $clog2(DEPTH);
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t             state, state_nxt;
  logic               push, push_brk, push_ext;
  logic [9:0]         mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [3:0]         count, count_nxt;
  logic               full, empty, pop, push_ok, drop, status_rd;
  logic [9:0]         head;

  // Prefix parser: only a non-prefix byte completes an event.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_brk  = 1'b0;
    push_ext  = 1'b0;
    if (Code_Valid) begin
      case (state)
        S_IDLE: begin
          if (Code_Byte == 8'hE0)      state_nxt = S_EXT;
          else if (Code_Byte == 8'hF0) state_nxt = S_BRK;
          else if (Code_Byte == 8'hAA || Code_Byte == 8'hFA || Code_Byte == 8'hEE)
            state_nxt = S_IDLE;
          else                         push = 1'b1;
        end
        S_EXT: begin
          if (Code_Byte == 8'hF0)      state_nxt = S_EXT_BRK;
          else if (Code_Byte != 8'hE0) begin
            push      = 1'b1;
            push_ext  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          if (Code_Byte == 8'hE0)      state_nxt = S_EXT_BRK;
          else if (Code_Byte != 8'hF0) begin
            push      = 1'b1;
            push_brk  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: begin
          if (Code_Byte != 8'hE0 && Code_Byte != 8'hF0) begin
            push      = 1'b1;
            push_brk  = 1'b1;
            push_ext  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      endcase
    end
  end

  assign full      = (count == FULL_CNT);
  assign empty     = (count == 4'd0);
  assign pop       = Read_Strobe && (Port_ID == PORT_FLAGS) && !empty;
  // A pop frees the slot in the same cycle, so a push on a full FIFO is kept.
  assign push_ok   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign status_rd = Read_Strobe && (Port_ID == PORT_STATUS);

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + 4'd1;
      2'b01:   count_nxt = count - 4'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= S_IDLE;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= 4'd0;
      Event_Pending <= 1'b0;
      Overflow      <= 1'b0;
    end else begin
      state         <= state_nxt;
      count         <= count_nxt;
      Event_Pending <= (count_nxt != 4'd0);
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      // A drop in the same cycle as a status read keeps the flag set.
      if (drop)           Overflow <= 1'b1;
      else if (status_rd) Overflow <= 1'b0;
    end
  end

  // Entry storage holds data only; validity is tracked by count.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= {push_brk, push_ext, Code_Byte};
  end

  assign head = mem[rd_ptr];

  always_comb begin
    Port_Out = 8'h00;
    if (Port_ID == PORT_STATUS)                Port_Out = {Overflow, 3'b000, count};
    else if (Port_ID == PORT_KEY && !empty)    Port_Out = head[7:0];
    else if (Port_ID == PORT_FLAGS && !empty)  Port_Out = {6'b0, head[8], head[9]};
  end

endmodule
